// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream mux: arbitration mode codes
// and the channel-index width derivation.
package stream_mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // A single channel still needs a one-bit index so O_SEL is never zero-width.
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from ptr, or fixed priority with
// the lowest index winning. Searches a doubled request vector to handle wrap.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N     = 8,
  parameter int SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  logic [2*N-1:0] req2;
  int             start;
  int             pos;

  assign req2 = {req, req};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    start     = 0;
    pos       = 0;
    case (mode)
      MODE_RR:    start = (int'(ptr) < N) ? int'(ptr) : 0;
      MODE_FIXED: start = 0;
      default:    start = 0;
    endcase
    // Scan from the far end so the closest request to start is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req2[start + i]) begin
        pos = start + i;
        if (pos >= N) pos = pos - N;
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(pos);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream mux with internal round-robin / fixed-priority
// arbitration, packet locking until LAST, and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int WIDTH = 8,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               MODE,
  input  logic [N*WIDTH-1:0] I_DATA,
  input  logic [N-1:0]       I_VALID,
  input  logic [N-1:0]       I_LAST,
  output logic [N-1:0]       I_READY,
  output logic [WIDTH-1:0]   O_DATA,
  output logic               O_LAST,
  output logic [SEL_W-1:0]   O_SEL,
  output logic               O_VALID,
  input  logic               O_READY
);

  logic             load;
  logic             accept;
  logic             arb_valid;
  logic [SEL_W-1:0] arb_idx;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic             lock_q;
  logic [SEL_W-1:0] lock_ch_q;
  logic [SEL_W-1:0] ptr_q;

  rr_arbiter #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (I_VALID),
    .ptr       (ptr_q),
    .mode      (MODE),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  assign load = !O_VALID || O_READY;

  // While locked only the packet owner may be granted; an idle owner yields a bubble.
  assign gnt_valid = lock_q ? I_VALID[lock_ch_q] : arb_valid;
  assign gnt_idx   = lock_q ? lock_ch_q : arb_idx;

  // Nothing is accepted during reset since the register would discard it anyway.
  assign accept = load && gnt_valid && !RESET;

  always_comb begin
    I_READY = '0;
    if (accept) I_READY[gnt_idx] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (RESET) begin
      O_VALID   <= 1'b0;
      O_DATA    <= '0;
      O_LAST    <= 1'b0;
      O_SEL     <= '0;
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
    end else if (load) begin
      O_VALID <= accept;
      if (accept) begin
        O_DATA <= I_DATA[gnt_idx*WIDTH +: WIDTH];
        O_LAST <= I_LAST[gnt_idx];
        O_SEL  <= gnt_idx;
        if (I_LAST[gnt_idx]) begin
          lock_q <= 1'b0;
          ptr_q  <= (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end else begin
          lock_q    <= 1'b1;
          lock_ch_q <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: vector table on an 8-channel instance,
// hand-written priority/wrap sequence on a 5-channel instance.
module tb_stream_mux_rr;

  logic clk;
  int   n_checks;
  int   n_errors;

  // 8-channel instance
  logic        r8;
  logic        m8;
  logic [63:0] d8;
  logic [7:0]  v8;
  logic [7:0]  l8;
  logic [7:0]  irdy8;
  logic [7:0]  od8;
  logic        ol8;
  logic [2:0]  os8;
  logic        ov8;
  logic        ordy8;

  // 5-channel instance
  logic        r5;
  logic        m5;
  logic [39:0] d5;
  logic [4:0]  v5;
  logic [4:0]  l5;
  logic [4:0]  irdy5;
  logic [7:0]  od5;
  logic        ol5;
  logic [2:0]  os5;
  logic        ov5;
  logic        ordy5;

  stream_mux_rr #(.N(8), .WIDTH(8)) dut8 (
    .CLK(clk), .RESET(r8), .MODE(m8), .I_DATA(d8), .I_VALID(v8), .I_LAST(l8),
    .I_READY(irdy8), .O_DATA(od8), .O_LAST(ol8), .O_SEL(os8), .O_VALID(ov8),
    .O_READY(ordy8)
  );

  stream_mux_rr #(.N(5), .WIDTH(8)) dut5 (
    .CLK(clk), .RESET(r5), .MODE(m5), .I_DATA(d5), .I_VALID(v5), .I_LAST(l5),
    .I_READY(irdy5), .O_DATA(od5), .O_LAST(ol5), .O_SEL(os5), .O_VALID(ov5),
    .O_READY(ordy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        mode;
    logic [7:0]  valid;
    logic [7:0]  last;
    logic        ordy;
    logic [63:0] data;
    logic        chk;
    logic        ovalid;
    logic [2:0]  osel;
    logic [7:0]  odata;
    logic        olast;
    logic [7:0]  irdy;
  } vec_t;

  localparam int NV = 31;
  // Channel k byte is k*16 unless a row overrides it.
  localparam logic [63:0] DB  = 64'h7060_5040_3020_1000;
  localparam logic [63:0] D21 = 64'h7060_5040_3021_1000;
  localparam logic [63:0] D22 = 64'h7060_5040_3022_1000;
  localparam logic [63:0] DA5 = 64'h7060_A540_3020_1000;
  localparam logic [63:0] DB5 = 64'h7060_B540_3020_1000;
  localparam logic [63:0] D61 = 64'h7061_5040_3020_1000;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    // Expected outputs are observed during the row's cycle, i.e. before its edge.
    //            rst mode valid  last   ordy data chk  ov sel odata  ol irdy
    vecs[0]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vecs[1]  = '{1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h01};
    vecs[3]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 8'h02};
    vecs[4]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd1, 8'h10, 1'b1, 8'h04};
    vecs[5]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd2, 8'h20, 1'b1, 8'h08};
    vecs[6]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd3, 8'h30, 1'b1, 8'h10};
    vecs[7]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd4, 8'h40, 1'b1, 8'h20};
    vecs[8]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd5, 8'h50, 1'b1, 8'h40};
    vecs[9]  = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd6, 8'h60, 1'b1, 8'h80};
    vecs[10] = '{1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, DB,  1'b1, 1'b1, 3'd7, 8'h70, 1'b1, 8'h01};
    // ch2 three-beat packet with ch3 waiting; ch2 idles one cycle mid-packet
    vecs[11] = '{1'b0, 1'b0, 8'h0C, 8'h08, 1'b1, DB,  1'b1, 1'b1, 3'd0, 8'h00, 1'b1, 8'h04};
    vecs[12] = '{1'b0, 1'b0, 8'h08, 8'h08, 1'b1, DB,  1'b1, 1'b1, 3'd2, 8'h20, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 1'b0, 8'h0C, 8'h08, 1'b1, D21, 1'b1, 1'b0, 3'd2, 8'h20, 1'b0, 8'h04};
    vecs[14] = '{1'b0, 1'b0, 8'h0C, 8'h0C, 1'b1, D22, 1'b1, 1'b1, 3'd2, 8'h21, 1'b0, 8'h04};
    vecs[15] = '{1'b0, 1'b0, 8'h08, 8'h08, 1'b1, DB,  1'b1, 1'b1, 3'd2, 8'h22, 1'b1, 8'h08};
    // back-pressure on ch5
    vecs[16] = '{1'b0, 1'b0, 8'h20, 8'h20, 1'b1, DA5, 1'b1, 1'b1, 3'd3, 8'h30, 1'b1, 8'h20};
    vecs[17] = '{1'b0, 1'b0, 8'h20, 8'h20, 1'b0, DB5, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b1, 8'h00};
    vecs[18] = '{1'b0, 1'b0, 8'h20, 8'h20, 1'b0, DB5, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b1, 8'h00};
    vecs[19] = '{1'b0, 1'b0, 8'h20, 8'h20, 1'b0, DB5, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b1, 8'h00};
    vecs[20] = '{1'b0, 1'b0, 8'h20, 8'h20, 1'b0, DB5, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b1, 8'h00};
    vecs[21] = '{1'b0, 1'b0, 8'h20, 8'h20, 1'b1, DB5, 1'b1, 1'b1, 3'd5, 8'hA5, 1'b1, 8'h20};
    vecs[22] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, DB,  1'b1, 1'b1, 3'd5, 8'hB5, 1'b1, 8'h00};
    // reset in the middle of a ch6 packet
    vecs[23] = '{1'b0, 1'b0, 8'h40, 8'h00, 1'b1, DB,  1'b1, 1'b0, 3'd5, 8'hB5, 1'b1, 8'h40};
    vecs[24] = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b1, D61, 1'b1, 1'b1, 3'd6, 8'h60, 1'b0, 8'h00};
    vecs[25] = '{1'b0, 1'b0, 8'h42, 8'h42, 1'b1, DB,  1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 8'h02};
    vecs[26] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, DB,  1'b1, 1'b1, 3'd1, 8'h10, 1'b1, 8'h00};
    // MODE flips to fixed mid-packet; ch3 keeps the grant over ch1
    vecs[27] = '{1'b0, 1'b0, 8'h0A, 8'h00, 1'b1, DB,  1'b1, 1'b0, 3'd1, 8'h10, 1'b1, 8'h08};
    vecs[28] = '{1'b0, 1'b1, 8'h0A, 8'h08, 1'b1, DB,  1'b1, 1'b1, 3'd3, 8'h30, 1'b0, 8'h08};
    vecs[29] = '{1'b0, 1'b1, 8'h02, 8'h02, 1'b1, DB,  1'b1, 1'b1, 3'd3, 8'h30, 1'b1, 8'h02};
    vecs[30] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, DB,  1'b1, 1'b1, 3'd1, 8'h10, 1'b1, 8'h00};

    r5 = 1'b1; m5 = 1'b0; d5 = 40'hC4C3C2C1C0; v5 = '0; l5 = '1; ordy5 = 1'b1;
    r8 = 1'b1; m8 = 1'b0; d8 = DB; v8 = '0; l8 = '0; ordy8 = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      r8    = vecs[i].rst;
      m8    = vecs[i].mode;
      v8    = vecs[i].valid;
      l8    = vecs[i].last;
      ordy8 = vecs[i].ordy;
      d8    = vecs[i].data;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d.o_valid", i), 64'(ov8),   64'(vecs[i].ovalid));
        check($sformatf("v%0d.o_sel",   i), 64'(os8),   64'(vecs[i].osel));
        check($sformatf("v%0d.o_data",  i), 64'(od8),   64'(vecs[i].odata));
        check($sformatf("v%0d.o_last",  i), 64'(ol8),   64'(vecs[i].olast));
        check($sformatf("v%0d.i_ready", i), 64'(irdy8), 64'(vecs[i].irdy));
      end
    end

    // N=5: fixed priority, then round-robin wrap from ch4 back to ch0
    @(negedge clk);
    #1;
    check("n5.reset_o_valid", 64'(ov5), 64'd0);
    check("n5.reset_i_ready", 64'(irdy5), 64'd0);
    @(negedge clk);
    r5 = 1'b0; m5 = 1'b1; v5 = 5'b10010;
    #1;
    check("n5.fixed_i_ready", 64'(irdy5), 64'(5'b00010));
    @(negedge clk);
    m5 = 1'b0; v5 = 5'b10000;
    #1;
    check("n5.fixed_o_sel", 64'(os5), 64'd1);
    check("n5.fixed_o_data", 64'(od5), 64'hC1);
    check("n5.rr_ch4_i_ready", 64'(irdy5), 64'(5'b10000));
    @(negedge clk);
    v5 = 5'b10001;
    #1;
    check("n5.rr_ch4_o_sel", 64'(os5), 64'd4);
    check("n5.rr_ch4_o_data", 64'(od5), 64'hC4);
    check("n5.wrap_i_ready", 64'(irdy5), 64'(5'b00001));
    @(negedge clk);
    v5 = '0;
    #1;
    check("n5.wrap_o_valid", 64'(ov5), 64'd1);
    check("n5.wrap_o_sel", 64'(os5), 64'd0);
    check("n5.wrap_o_data", 64'(od5), 64'hC0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
